fibo_arbiter: RTL



---
 rtl/fibo_arbiter_if.sv | 46 ++++
 rtl/fibo_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fibo_arbiter_if.sv
// fibo_arbiter_if: bundles the two requester ports and the shared-engine port
// of fibo_arbiter.
//   req0/req1       requester n asks for a job, held until its ack
//   count0/count1   job length for requester n
//   ack0/ack1       one-cycle completion pulse for requester n
//   result0/1       result for requester n, held until its next ack
//   err0/err1       high with ackn when the job timed out
//   eng_start       one-cycle start pulse to the engine
//   eng_count       latched count of the granted job
//   eng_done        engine done level
//   eng_data        engine result
//   busy            arbiter not idle
//   grant           index of the requester currently or last served
// slave is the arbiter side; master is the requester/engine side.
interface fibo_arbiter_if #(
   parameter int SIZE = 4
) ();
   logic            req0;
   logic            req1;
   logic [SIZE-1:0] count0;
   logic [SIZE-1:0] count1;
   logic            ack0;
   logic            ack1;
   logic [SIZE-1:0] result0;
   logic [SIZE-1:0] result1;
   logic            err0;
   logic            err1;
   logic            eng_start;
   logic [SIZE-1:0] eng_count;
   logic            eng_done;
   logic [SIZE-1:0] eng_data;
   logic            busy;
   logic            grant;

   modport slave (
      input  req0, req1, count0, count1, eng_done, eng_data,
      output ack0, ack1, result0, result1, err0, err1,
             eng_start, eng_count, busy, grant
   );

   modport master (
      output req0, req1, count0, count1, eng_done, eng_data,
      input  ack0, ack1, result0, result1, err0, err1,
             eng_start, eng_count, busy, grant
   );
endinterface

// File: rtl/fibo_arbiter.sv
// fibo_arbiter: round-robin arbiter giving two requesters access to one shared
// Fibonacci engine, with a WAIT timeout and a stale-done filter.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fibo_arbiter_if.slave (requester and engine signals)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for an eligible request; grants and latches its count
// S_LAUNCH | eng_start pulse; arms the done filter and clears the timer
// S_WAIT   | waiting for an accepted done rise or the timeout
// S_RESP   | ack pulse to the granted requester (err on timeout)
module fibo_arbiter #(
   parameter int SIZE    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   fibo_arbiter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

   // Timer value in the last allowed WAIT cycle: TIMEOUT WAIT cycles in total.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic            grant_q, grant_d;
   logic [1:0]      drop_q, drop_d;
   logic            armed_q, armed_d;
   logic [7:0]      tmr_q, tmr_d;
   logic [SIZE-1:0] eng_count_q, eng_count_d;
   logic [SIZE-1:0] result0_q, result0_d;
   logic [SIZE-1:0] result1_q, result1_d;
   logic            timed_out_q, timed_out_d;

   logic [1:0]      elig;
   logic            pick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         drop_q       <= '0;
         armed_q      <= 1'b0;
         tmr_q        <= '0;
         eng_count_q  <= '0;
         result0_q    <= '0;
         result1_q    <= '0;
         timed_out_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         drop_q       <= drop_d;
         armed_q      <= armed_d;
         tmr_q        <= tmr_d;
         eng_count_q  <= eng_count_d;
         result0_q    <= result0_d;
         result1_q    <= result1_d;
         timed_out_q  <= timed_out_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      drop_d       = drop_q;
      armed_d      = armed_q;
      tmr_d        = tmr_q;
      eng_count_d  = eng_count_q;
      result0_d    = result0_q;
      result1_d    = result1_q;
      timed_out_d  = timed_out_q;
      pick         = 1'b0;
      elig         = {bus.req1 & ~drop_q[1], bus.req0 & ~drop_q[0]};

      case (state_q)
         S_IDLE: begin
            if (elig != 2'b00) begin
               // On a tie the requester that was not served last wins.
               pick         = (elig == 2'b11) ? ~last_grant_q : elig[1];
               grant_d      = pick;
               last_grant_d = pick;
               eng_count_d  = pick ? bus.count1 : bus.count0;
               timed_out_d  = 1'b0;
               if (eng_count_d == '0) begin
                  state_d = S_RESP;
                  if (pick) result1_d = '0;
                  else      result0_d = '0;
               end else begin
                  state_d = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            armed_d = 1'b0;
            tmr_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            tmr_d = tmr_q + 8'd1;
            // A done level that was already high at launch belongs to the
            // previous job; only accept it after a low has been seen.
            if (!bus.eng_done) armed_d = 1'b1;
            if (bus.eng_done && armed_q) begin
               if (grant_q) result1_d = bus.eng_data;
               else         result0_d = bus.eng_data;
               timed_out_d = 1'b0;
               state_d     = S_RESP;
            end else if (tmr_q == TMO_LAST) begin
               if (grant_q) result1_d = '0;
               else         result0_d = '0;
               timed_out_d = 1'b1;
               state_d     = S_RESP;
            end
         end
         S_RESP: begin
            drop_d[grant_q] = 1'b1;
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A low request always clears the drop flag, even in the ack cycle.
      drop_d = drop_d & {bus.req1, bus.req0};
   end

   assign bus.ack0      = (state_q == S_RESP) & ~grant_q;
   assign bus.ack1      = (state_q == S_RESP) & grant_q;
   assign bus.err0      = bus.ack0 & timed_out_q;
   assign bus.err1      = bus.ack1 & timed_out_q;
   assign bus.eng_start = (state_q == S_LAUNCH);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.grant     = grant_q;
   assign bus.eng_count = eng_count_q;
   assign bus.result0   = result0_q;
   assign bus.result1   = result1_q;
endmodule
